// File: rtl/dma_cmd_rx_if.sv
// dma_cmd_rx_if: received-frame beat stream plus the command-FIFO and start-token-FIFO write ports.
interface dma_cmd_rx_if;
    logic        rx_valid;
    logic [31:0] rx_data;
    logic        rx_sof;
    logic        rx_eof;
    logic        rx_err;
    logic        rx_ready;
    logic        cmd_fifo_we;
    logic [31:0] cmd_fifo_data;
    logic        cmd_fifo_full;
    logic        start_dma_we;
    logic        start_dma_full;
    logic [7:0]  frame_count;
    logic [7:0]  drop_count;
    modport slave (
        input  rx_valid, rx_data, rx_sof, rx_eof, rx_err, cmd_fifo_full, start_dma_full,
        output rx_ready, cmd_fifo_we, cmd_fifo_data, start_dma_we, frame_count, drop_count
    );
    modport master (
        output rx_valid, rx_data, rx_sof, rx_eof, rx_err, cmd_fifo_full, start_dma_full,
        input  rx_ready, cmd_fifo_we, cmd_fifo_data, start_dma_we, frame_count, drop_count
    );
endinterface

// File: rtl/dma_cmd_rx.sv
// dma_cmd_rx: stages a framed batch of command/address pairs and, only once the whole frame
// has arrived intact, replays it into the command FIFO followed by one start token.
module dma_cmd_rx #(
    parameter logic [15:0] MAGIC     = 16'hDA7A,
    parameter int          MAX_PAIRS = 16
) (
    input logic         clk,
    input logic         reset,
    dma_cmd_rx_if.slave b
);
    localparam int DEPTH = 2 * MAX_PAIRS;
    localparam int PW    = $clog2(DEPTH + 1);
    localparam int IW    = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, COLLECT, DROP, COMMIT, START} state_t;

    state_t        state, state_n;
    logic [PW-1:0] wr_ptr, wr_n, rd_ptr, rd_n, expected, exp_n, words;
    logic [7:0]    frame_count, frame_n, drop_count;
    logic [1:0]    drop_inc;
    logic [8:0]    drop_sum;
    logic [4:0]    npairs;
    logic          hdr_ok, acc, stg_we, good;
    logic [31:0]   staging [DEPTH];

    assign npairs          = b.rx_data[4:0];
    assign hdr_ok          = b.rx_data[31:16] == MAGIC && npairs != 5'd0 && {27'd0, npairs} <= MAX_PAIRS;
    assign b.rx_ready      = state inside {IDLE, COLLECT, DROP};
    assign acc             = b.rx_valid && b.rx_ready;
    assign b.cmd_fifo_we   = state == COMMIT && !b.cmd_fifo_full && !reset;
    assign b.start_dma_we  = state == START && !b.start_dma_full && !reset;
    assign b.cmd_fifo_data = staging[rd_ptr[IW-1:0]];
    assign b.frame_count   = frame_count;
    assign b.drop_count    = drop_count;
    assign words           = wr_ptr + PW'(1);
    assign good            = !b.rx_err && words == expected;
    assign drop_sum        = {1'b0, drop_count} + {7'd0, drop_inc};

    // A sof beat is always a new header; if a frame was in flight it is aborted in the same cycle.
    always_comb begin
        state_n  = state;
        wr_n     = wr_ptr;
        rd_n     = rd_ptr;
        exp_n    = expected;
        frame_n  = frame_count;
        drop_inc = 2'd0;
        stg_we   = 1'b0;
        if (acc && b.rx_sof) begin
            drop_inc = {1'b0, state != IDLE} + {1'b0, b.rx_eof};
            state_n  = b.rx_eof ? IDLE : hdr_ok ? COLLECT : DROP;
            exp_n    = PW'({npairs, 1'b0});
            wr_n     = '0;
        end else if (acc && state == COLLECT) begin
            if (words > expected) begin
                state_n  = b.rx_eof ? IDLE : DROP;
                drop_inc = {1'b0, b.rx_eof};
            end else begin
                stg_we = 1'b1;
                wr_n   = words;
                if (b.rx_eof) begin
                    state_n  = good ? COMMIT : IDLE;
                    drop_inc = {1'b0, !good};
                    rd_n     = '0;
                end
            end
        end else if (acc && state == DROP && b.rx_eof) begin
            state_n  = IDLE;
            drop_inc = 2'd1;
        end else if (b.cmd_fifo_we) begin
            rd_n    = rd_ptr + PW'(1);
            state_n = rd_ptr == expected - PW'(1) ? START : COMMIT;
        end else if (b.start_dma_we) begin
            frame_n = frame_count + 8'd1;
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            expected    <= '0;
            frame_count <= '0;
            drop_count  <= '0;
        end else begin
            state       <= state_n;
            wr_ptr      <= wr_n;
            rd_ptr      <= rd_n;
            expected    <= exp_n;
            frame_count <= frame_n;
            drop_count  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    always_ff @(posedge clk)
        if (stg_we) staging[wr_ptr[IW-1:0]] <= b.rx_data;
endmodule
